// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative MULTU/DIVU sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } muldiv_state_e;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for MULTU, trial-subtract/shift for DIVU.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            op_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, hi_i} + {1'b0, opnd_i};
    shifted = {hi_i, lo_i[XLEN-1]};
    trial   = shifted - {1'b0, opnd_i};
    hi_o    = hi_i;
    lo_o    = lo_i;
    if (op_i == OP_MULTU) begin
      // {hi, lo} is the 64-bit accumulator; lo's low bit is the current multiplier bit.
      if (lo_i[0]) begin
        hi_o = sum[XLEN:1];
        lo_o = {sum[0], lo_i[XLEN-1:1]};
      end else begin
        hi_o = {1'b0, hi_i[XLEN-1:1]};
        lo_o = {hi_i[0], lo_i[XLEN-1:1]};
      end
    end else begin
      // hi is the partial remainder, lo shifts the dividend out and the quotient in.
      if (!trial[XLEN]) begin
        hi_o = trial[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULTU/DIVU sequencer owning HI/LO; stalls the front of the pipe until the result commits.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] w_hi_q, w_hi_d;
  logic [XLEN-1:0] w_lo_q, w_lo_d;
  logic [XLEN-1:0] w_opnd_q, w_opnd_d;
  logic [XLEN-1:0] step_hi, step_lo;

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .op_i   (op_q),
    .hi_i   (w_hi_q),
    .lo_i   (w_lo_q),
    .opnd_i (w_opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    w_hi_d   = w_hi_q;
    w_lo_d   = w_lo_q;
    w_opnd_d = w_opnd_q;
    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          op_d     = op;
          w_hi_d   = '0;
          w_lo_d   = a;
          w_opnd_d = b;
          cnt_d    = CntW'(XLEN);
          // Divide-by-zero commits immediately and overrides any same-cycle MT write.
          if (op == OP_DIVU && b == '0) begin
            hi_d    = a;
            lo_d    = XLEN'(DIV0_LO);
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          w_hi_d = step_hi;
          w_lo_d = step_lo;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OP_MULTU;
      hi_q     <= '0;
      lo_q     <= '0;
      w_hi_q   <= '0;
      w_lo_q   <= '0;
      w_opnd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      w_hi_q   <= w_hi_d;
      w_lo_q   <= w_lo_d;
      w_opnd_q <= w_opnd_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == StBusy);
  assign done  = (state_q == StDone);
  assign stall = ((state_q == StIdle) && start && !flush) || (state_q == StBusy);

endmodule
